rv32_wb_arbiter: RTL and testbench

RV32_WB_ARBITER -- requirements
Module: rv32_wb_arbiter

---
 rtl/rv32_wb_arbiter_if.sv | 36 +++
 rtl/rv32_wb_arbiter.sv | 109 ++++++++++
 tb/tb_rv32_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_wb_arbiter_if.sv
// Writeback bus between the two result sources (ALU, load unit), the
// writeback arbiter and the register-file write port.
interface rv32_wb_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [31:0]      alu_data;
    logic             alu_ready;

    logic             mem_valid;
    logic [4:0]       mem_rd;
    logic [31:0]      mem_data;
    logic             mem_ready;

    logic             wr_en;
    logic [4:0]       rd_address;
    logic [31:0]      rd_data;
    logic [CNT_W-1:0] conflict_cnt;

    // Requester / register-file side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  wr_en, rd_address, rd_data, conflict_cnt
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output wr_en, rd_address, rd_data, conflict_cnt
    );
endinterface

// File: rtl/rv32_wb_arbiter.sv
// Writeback arbiter: shares one register-file write port between the ALU
// and load results. Conflicts are resolved round-robin; the write is
// registered one cycle after the accept. Writes to x0 are consumed but
// never enabled.
//
// Round-robin pointer states (last conflict winner):
//   state   | meaning
//   PTR_ALU | ALU won the last conflict, MEM wins the next one (reset)
//   PTR_MEM | MEM won the last conflict, ALU wins the next one
module rv32_wb_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    rv32_wb_arbiter_if.slave   bus
);

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_MEM = 1'b1
    } ptr_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ptr_e             ptr_q, ptr_d;
    logic             conflict;
    logic             alu_ready, mem_ready;
    logic             alu_acc, mem_acc;

    logic             wr_en_q, wr_en_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Pointer register; reset points at ALU so MEM takes the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant decode: ready depends only on valids, pointer and reset, never on payload.
    always_comb begin
        ptr_d     = ptr_q;
        alu_ready = 1'b1;
        mem_ready = 1'b1;
        conflict  = bus.alu_valid & bus.mem_valid;
        if (rst) begin
            alu_ready = 1'b0;
            mem_ready = 1'b0;
        end else if (conflict) begin
            if (ptr_q == PTR_ALU) begin
                alu_ready = 1'b0;
                ptr_d     = PTR_MEM;
            end else begin
                mem_ready = 1'b0;
                ptr_d     = PTR_ALU;
            end
        end
    end

    assign alu_acc = bus.alu_valid & alu_ready;
    assign mem_acc = bus.mem_valid & mem_ready;

    // Next write-port values; address/data hold when nothing is accepted.
    always_comb begin
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        cnt_d     = cnt_q;
        if (alu_acc) begin
            wr_en_d   = |bus.alu_rd;
            rd_addr_d = bus.alu_rd;
            rd_data_d = bus.alu_data;
        end else if (mem_acc) begin
            wr_en_d   = |bus.mem_rd;
            rd_addr_d = bus.mem_rd;
            rd_data_d = bus.mem_data;
        end
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Output registers; reset also drops a write captured the cycle before.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
            cnt_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.alu_ready    = alu_ready;
    assign bus.mem_ready    = mem_ready;
    assign bus.wr_en        = wr_en_q;
    assign bus.rd_address   = rd_addr_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Bench for the writeback arbiter: a reference model predicts ready and the
// registered write each cycle; predicted writes go through a queue and are
// compared after the clock edge.
module tb_rv32_wb_arbiter;

    localparam int CNT_W = 4;

    logic clk;
    logic rst;

    rv32_wb_arbiter_if #(.CNT_W(CNT_W)) bus ();

    rv32_wb_arbiter #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_err;

    logic [37:0] exp_q[$];

    // model state
    logic             m_ptr_mem;   // 1: MEM won last conflict
    logic [CNT_W-1:0] m_cnt;
    logic [4:0]       m_addr;
    logic [31:0]      m_data;

    logic last_a_acc;
    logic last_m_acc;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.mem_valid = v;
        bus.mem_rd    = rd;
        bus.mem_data  = d;
    endtask

    // One clock cycle: check ready before the edge, check registered outputs after.
    task automatic step();
        logic        e_ar, e_mr, conf, gm, a_acc, m_acc, e_wr;
        logic [37:0] got;
        logic [37:0] exp;
        #1;
        conf = bus.alu_valid && bus.mem_valid;
        gm   = !m_ptr_mem;
        if (rst) begin
            e_ar = 1'b0;
            e_mr = 1'b0;
        end else if (conf) begin
            e_ar = !gm;
            e_mr = gm;
        end else begin
            e_ar = 1'b1;
            e_mr = 1'b1;
        end
        check_val("alu_ready", bus.alu_ready, e_ar);
        check_val("mem_ready", bus.mem_ready, e_mr);
        a_acc = bus.alu_valid && e_ar;
        m_acc = bus.mem_valid && e_mr;

        e_wr = 1'b0;
        if (rst) begin
            m_addr    = 5'd0;
            m_data    = 32'd0;
            m_cnt     = '0;
            m_ptr_mem = 1'b0;
        end else begin
            if (a_acc) begin
                e_wr   = (bus.alu_rd != 5'd0);
                m_addr = bus.alu_rd;
                m_data = bus.alu_data;
            end else if (m_acc) begin
                e_wr   = (bus.mem_rd != 5'd0);
                m_addr = bus.mem_rd;
                m_data = bus.mem_data;
            end
            if (conf) begin
                m_ptr_mem = gm;
                if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            end
        end
        exp_q.push_back({e_wr, m_addr, m_data});
        last_a_acc = a_acc;
        last_m_acc = m_acc;

        @(posedge clk);
        #1;
        got = {bus.wr_en, bus.rd_address, bus.rd_data};
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check_val("wr_en", got[37], exp[37]);
            check_val("rd_address", got[36:32], exp[36:32]);
            check_val("rd_data", got[31:0], exp[31:0]);
        end
        check_val("conflict_cnt", bus.conflict_cnt, m_cnt);
    endtask

    task automatic do_reset();
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int a_wait;
    int m_wait;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        m_ptr_mem  = 1'b0;
        m_cnt      = '0;
        m_addr     = 5'd0;
        m_data     = 32'd0;
        last_a_acc = 1'b0;
        last_m_acc = 1'b0;

        // reset state
        do_reset();
        check_val("rst_wr_en", bus.wr_en, 0);
        check_val("rst_cnt", bus.conflict_cnt, 0);

        // single ALU request
        set_alu(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        check_val("alu_only_addr", bus.rd_address, 5);
        check_val("alu_only_data", bus.rd_data, 32'hDEADBEEF);
        set_alu(1'b0, 5'd0, 32'd0);
        step();
        check_val("alu_only_idle_wr", bus.wr_en, 0);

        // first conflict after reset: MEM wins, ALU follows
        do_reset();
        set_alu(1'b1, 5'd3, 32'h11);
        set_mem(1'b1, 5'd4, 32'h22);
        step();
        check_val("c1_mem_first", last_m_acc, 1);
        set_mem(1'b0, 5'd0, 32'd0);
        step();
        check_val("c1_alu_second", last_a_acc, 1);
        check_val("c1_addr", bus.rd_address, 3);
        set_alu(1'b0, 5'd0, 32'd0);
        step();
        check_val("c1_cnt", bus.conflict_cnt, 1);

        // sustained conflict, new payload after every accept
        do_reset();
        set_alu(1'b1, 5'd10, 32'hA000_0000);
        set_mem(1'b1, 5'd20, 32'hB000_0000);
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("alt_mem", last_m_acc, (i % 2) == 0);
            check_val("alt_alu", last_a_acc, (i % 2) == 1);
            if (last_a_acc) set_alu(1'b1, 5'd10 + 5'(i), 32'hA000_0000 + 32'(i));
            if (last_m_acc) set_mem(1'b1, 5'd20 + 5'(i), 32'hB000_0000 + 32'(i));
        end
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 32'd0);
        step();
        check_val("alt_cnt", bus.conflict_cnt, 6);

        // non-conflict grant leaves the pointer: ALU alone, then conflict -> ALU still due
        do_reset();
        set_alu(1'b1, 5'd1, 32'h1);
        set_mem(1'b1, 5'd2, 32'h2);
        step();                              // MEM wins
        set_mem(1'b0, 5'd0, 32'd0);
        step();                              // ALU alone
        set_alu(1'b1, 5'd6, 32'h66);
        step();                              // ALU alone again
        set_mem(1'b1, 5'd9, 32'h99);
        step();                              // conflict: ALU's turn
        check_val("ptr_hold_alu", last_a_acc, 1);
        set_alu(1'b0, 5'd0, 32'd0);
        step();
        set_mem(1'b0, 5'd0, 32'd0);
        step();

        // x0 load is consumed without a write
        set_mem(1'b1, 5'd0, 32'hFFFFFFFF);
        step();
        check_val("x0_wr_en", bus.wr_en, 0);
        check_val("x0_addr", bus.rd_address, 0);
        set_mem(1'b0, 5'd0, 32'd0);
        step();

        // same-rd conflict: later grant gives the final value
        set_alu(1'b1, 5'd8, 32'hAAAA);
        set_mem(1'b1, 5'd8, 32'hBBBB);
        step();
        if (last_a_acc) set_alu(1'b0, 5'd0, 32'd0);
        if (last_m_acc) set_mem(1'b0, 5'd0, 32'd0);
        step();
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 32'd0);
        check_val("same_rd_wr", bus.wr_en, 1);
        check_val("same_rd_addr", bus.rd_address, 8);
        step();

        // reset mid-stream drops the pending write; held requests re-arbitrate
        set_alu(1'b1, 5'd7, 32'h7777);
        step();
        rst = 1'b1;
        set_mem(1'b1, 5'd12, 32'hC0C0);
        step();
        check_val("rst_mid_wr_en", bus.wr_en, 0);
        check_val("rst_mid_cnt", bus.conflict_cnt, 0);
        step();
        rst = 1'b0;
        step();
        check_val("rst_rearb_mem", last_m_acc, 1);
        set_mem(1'b0, 5'd0, 32'd0);
        step();
        set_alu(1'b0, 5'd0, 32'd0);
        step();

        // saturation of the 4-bit counter
        do_reset();
        set_alu(1'b1, 5'd14, 32'hE);
        set_mem(1'b1, 5'd15, 32'hF);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check_val("cnt_sat", bus.conflict_cnt, 15);
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 32'd0);
        step();

        // random protocol-compliant traffic with fairness tracking
        do_reset();
        a_wait = 0;
        m_wait = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (bus.alu_valid) begin
                if (last_a_acc) begin
                    check_val("alu_fair", a_wait <= 1, 1);
                    a_wait = 0;
                end else begin
                    a_wait++;
                end
            end
            if (bus.mem_valid) begin
                if (last_m_acc) begin
                    check_val("mem_fair", m_wait <= 1, 1);
                    m_wait = 0;
                end else begin
                    m_wait++;
                end
            end
            if (!bus.alu_valid || last_a_acc)
                set_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            if (!bus.mem_valid || last_m_acc)
                set_mem(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        set_alu(1'b0, 5'd0, 32'd0);
        set_mem(1'b0, 5'd0, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
